// File: rtl/rv32_alu_pkg.sv
// rv32_alu_pkg: opcode/funct constants, ALU enable indices, FSM states and the one-hot decoder.
package rv32_alu_pkg;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam int ALU_EN_W = 10;
    localparam int EN_ADD   = 0;
    localparam int EN_SUB   = 1;
    localparam int EN_XOR   = 2;
    localparam int EN_OR    = 3;
    localparam int EN_AND   = 4;
    localparam int EN_SLL   = 5;
    localparam int EN_SRL   = 6;
    localparam int EN_SRA   = 7;
    localparam int EN_SLT   = 8;
    localparam int EN_SLTU  = 9;
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
    function automatic logic [ALU_EN_W-1:0] decode_en(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        logic [ALU_EN_W-1:0] en;
        logic alt, shift, ok;
        alt   = f7 == F7_ALT;
        shift = f3 == F3_SLL || f3 == F3_SR;
        // OP-IMM non-shifts carry immediate bits in funct7, so funct7 is only checked elsewhere
        ok    = f7 == F7_BASE || (alt && (f3 == F3_SR || (opc == OPC_OP && f3 == F3_ADD))) || (opc == OPC_OPIMM && !shift);
        en    = '0;
        case (f3)
            F3_ADD:  en[(alt && opc == OPC_OP) ? EN_SUB : EN_ADD] = 1'b1;
            F3_SLL:  en[EN_SLL] = 1'b1;
            F3_SLT:  en[EN_SLT] = 1'b1;
            F3_SLTU: en[EN_SLTU] = 1'b1;
            F3_XOR:  en[EN_XOR] = 1'b1;
            F3_SR:   en[alt ? EN_SRA : EN_SRL] = 1'b1;
            F3_OR:   en[EN_OR] = 1'b1;
            F3_AND:  en[EN_AND] = 1'b1;
        endcase
        return ((opc == OPC_OP || opc == OPC_OPIMM) && ok) ? en : '0;
    endfunction
endpackage

// File: rtl/rv32_regfile.sv
// rv32_regfile: x1..x31 storage with sync reset, one write port and three combinational reads; x0 reads 0.
module rv32_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] dbg_data
);
    logic [XLEN-1:0] mem [1:NREGS-1];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end
    assign rs1_data = rs1_addr == '0 ? '0 : mem[rs1_addr];
    assign rs2_data = rs2_addr == '0 ? '0 : mem[rs2_addr];
    assign dbg_data = dbg_addr == '0 ? '0 : mem[dbg_addr];
endmodule

// File: rtl/rv32_alu_sequencer.sv
// rv32_alu_sequencer: 4-cycle IDLE/DECODE/EXEC/WB issue and writeback controller for enable-gated ALU units.
module rv32_alu_sequencer import rv32_alu_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    input  logic [31:0]         instr,
    output logic                instr_ready,
    output logic [ALU_EN_W-1:0] alu_en,
    output logic [XLEN-1:0]     alu_rs1,
    output logic [XLEN-1:0]     alu_rs2,
    input  logic [XLEN-1:0]     alu_result,
    output logic                done,
    output logic                illegal,
    output logic                wb_en,
    output logic [4:0]          wb_addr,
    output logic [XLEN-1:0]     wb_data,
    input  logic [4:0]          dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);
    state_t state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [ALU_EN_W-1:0] alu_en_q, alu_en_d, dec_en;
    logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, res_q, res_d, rs1_val, rs2_val, b_raw, op_b;
    rv32_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk(clk), .rst_n(rst_n), .we(wb_en), .waddr(instr_q[11:7]), .wdata(res_q),
        .rs1_addr(instr_q[19:15]), .rs2_addr(instr_q[24:20]), .dbg_addr(dbg_addr),
        .rs1_data(rs1_val), .rs2_data(rs2_val), .dbg_data(dbg_data)
    );
    always_comb begin
        dec_en   = decode_en(instr_q[6:0], instr_q[14:12], instr_q[31:25]);
        b_raw    = instr_q[6:0] == OPC_OP ? rs2_val : {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
        // funct3 001/101 are the shifts; the count is truncated so the ALU never sees >31
        op_b     = instr_q[13:12] == 2'b01 ? {{(XLEN-5){1'b0}}, b_raw[4:0]} : b_raw;
        state_d  = state_q;
        instr_d  = instr_q;
        alu_en_d = '0;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        res_d    = res_q;
        case (state_q)
            IDLE: begin
                state_d = instr_valid ? DECODE : IDLE;
                instr_d = instr_valid ? instr : instr_q;
            end
            DECODE: begin
                state_d  = dec_en != '0 ? EXEC : IDLE;
                alu_en_d = dec_en;
                rs1_d    = rs1_val;
                rs2_d    = op_b;
            end
            EXEC: begin
                state_d = WB;
                res_d   = alu_result;
            end
            WB: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            alu_en_q <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            alu_en_q <= alu_en_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            res_q    <= res_d;
        end
    end
    assign instr_ready = rst_n && state_q == IDLE;
    assign alu_en      = alu_en_q;
    assign alu_rs1     = rs1_q;
    assign alu_rs2     = rs2_q;
    assign illegal     = state_q == DECODE && dec_en == '0;
    assign done        = state_q == WB;
    assign wb_en       = done && instr_q[11:7] != '0;
    assign wb_addr     = wb_en ? instr_q[11:7] : '0;
    assign wb_data     = wb_en ? res_q : '0;
endmodule

// File: tb/tb_rv32_alu_sequencer.sv
// tb_rv32_alu_sequencer: random and directed instructions against an ISA-level model, checked by a scoreboard monitor.
`timescale 1ns/1ps
module tb_rv32_alu_sequencer;
    typedef struct {
        logic        ill;
        logic [9:0]  en;
        logic [31:0] a;
        logic [31:0] b;
        logic        wbe;
        logic [4:0]  wba;
        logic [31:0] wbd;
    } exp_t;

    logic clk, rst_n, instr_valid, instr_ready, done, illegal, wb_en;
    logic [31:0] instr, alu_rs1, alu_rs2, alu_result, wb_data, dbg_data;
    logic [9:0] alu_en;
    logic [4:0] wb_addr, dbg_addr;

    int total = 0;
    int bad = 0;
    exp_t exp_q[$];
    longint acc_t[$];
    logic [31:0] regs [32];
    int f3op [8] = '{0, 5, 8, 9, 2, 6, 3, 4};
    bit exec_seen = 0;

    rv32_alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .alu_en(alu_en), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_result(alu_result),
        .done(done), .illegal(illegal), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_op(input int op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a ^ b;
            3: return a | b;
            4: return a & b;
            5: return a << b[4:0];
            6: return a >> b[4:0];
            7: return $signed(a) >>> b[4:0];
            8: return {31'b0, $signed(a) < $signed(b)};
            9: return {31'b0, a < b};
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        alu_result = 32'hDEADBEEF;
        for (int i = 0; i < 10; i++) if (alu_en[i]) alu_result = alu_op(i, alu_rs1, alu_rs2);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        int op;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [31:0] a, b;
        opc = ins[6:0];
        f7 = ins[31:25];
        f3 = ins[14:12];
        a = regs[ins[19:15]];
        b = 32'h0;
        op = -1;
        if (opc == 7'b0110011) begin
            b = regs[ins[24:20]];
            if (f7 == 7'h00) op = f3op[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) op = 1;
            else if (f7 == 7'h20 && f3 == 3'd5) op = 7;
        end else if (opc == 7'b0010011) begin
            b = {{20{ins[31]}}, ins[31:20]};
            if (f3 == 3'd1) op = f7 == 7'h00 ? 5 : -1;
            else if (f3 == 3'd5) op = f7 == 7'h00 ? 6 : (f7 == 7'h20 ? 7 : -1);
            else op = f3op[f3];
        end
        if (op >= 5 && op <= 7) b = {27'b0, b[4:0]};
        e.ill = op < 0;
        e.en  = e.ill ? 10'h0 : 10'(1 << op);
        e.a   = a;
        e.b   = b;
        e.wbd = alu_op(op, a, b);
        e.wba = ins[11:7];
        e.wbe = !e.ill && e.wba != 5'd0;
        if (e.wbe) regs[e.wba] = e.wbd;
        return e;
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0] f7;
        logic [4:0] rd, r1, r2;
        w  = $urandom();
        rd = 5'($urandom_range(0, 7));
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        f7 = $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
        if ($urandom_range(0, 7) == 0) f7 = w[31:25];
        case ($urandom_range(0, 9))
            0: return w;
            1, 2, 3, 4: return enc_r(f7, r2, r1, w[14:12], rd);
            default: return enc_i((w[13:12] == 2'b01) ? {f7, r2} : w[11:0], r1, w[14:12], rd);
        endcase
    endfunction

    task automatic issue(input logic [31:0] ins, input bit keep);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("ready timeout", 32'(instr_ready), 32'd1);
            return;
        end
        instr = ins;
        instr_valid = 1;
        exp_q.push_back(model(ins));
        @(posedge clk);
        acc_t.push_back($time);
        #1;
        if (!keep) instr_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !instr_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain pending", exp_q.size(), 0);
    endtask

    task automatic scan_regs();
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk($sformatf("dbg x%0d", i), dbg_data, regs[i]);
        end
    endtask

    task automatic check_quiet(input logic rdy);
        chk("q instr_ready", 32'(instr_ready), 32'(rdy));
        chk("q alu_en", 32'(alu_en), 0);
        chk("q alu_rs1", alu_rs1, 0);
        chk("q alu_rs2", alu_rs2, 0);
        chk("q done", 32'(done), 0);
        chk("q illegal", 32'(illegal), 0);
        chk("q wb_en", 32'(wb_en), 0);
        chk("q wb_addr", 32'(wb_addr), 0);
        chk("q wb_data", wb_data, 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exec_seen <= 0;
        end else begin
            chk("alu_en onehot", 32'($countones(alu_en) <= 1), 32'd1);
            if (alu_en != 10'h0) begin
                if (exp_q.size() == 0) chk("exec without instr", 32'(alu_en), 0);
                else begin
                    chk("alu_en", 32'(alu_en), 32'(exp_q[0].en));
                    chk("alu_rs1", alu_rs1, exp_q[0].a);
                    chk("alu_rs2", alu_rs2, exp_q[0].b);
                    exec_seen <= 1;
                end
            end
            if (done || illegal) begin
                if (exp_q.size() == 0) chk("unexpected retire", {30'b0, done, illegal}, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("illegal", 32'(illegal), 32'(e.ill));
                    chk("done", 32'(done), 32'(!e.ill));
                    chk("wb_en", 32'(wb_en), 32'(e.wbe));
                    if (e.wbe) begin
                        chk("wb_addr", 32'(wb_addr), 32'(e.wba));
                        chk("wb_data", wb_data, e.wbd);
                    end
                    if (!e.ill) chk("exec seen", 32'(exec_seen), 32'd1);
                    exec_seen <= 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_n = 0;
        instr_valid = 0;
        instr = 0;
        dbg_addr = 0;
        foreach (regs[i]) regs[i] = 0;
        repeat (2) @(negedge clk);
        check_quiet(1'b0);
        scan_regs();
        rst_n = 1;
        #1;
        chk("ready after reset", 32'(instr_ready), 32'd1);
        issue(32'h00500093, 0);
        issue(enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd2), 0);
        issue(enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd3), 0);
        issue(enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd4), 0);
        issue(enc_i(12'h021, 5'd0, 3'd0, 5'd6), 0);
        issue(enc_r(7'h00, 5'd6, 5'd1, 3'd1, 5'd5), 0);
        issue(enc_i(12'h001, 5'd0, 3'd0, 5'd8), 0);
        issue(enc_i(12'd31, 5'd8, 3'd1, 5'd8), 0);
        issue(enc_i(12'h404, 5'd8, 3'd5, 5'd9), 0);
        drain();
        scan_regs();
        chk("x2 sub", regs[2], 32'hFFFFFFFB);
        chk("x5 sll", regs[5], 32'h0000000A);
        issue(enc_r(7'h01, 5'd1, 5'd1, 3'd0, 5'd10), 1);
        issue(32'h00002503, 1);
        issue(enc_i(12'd7, 5'd0, 3'd0, 5'd0), 1);
        issue(enc_i(12'd3, 5'd1, 3'd0, 5'd11), 1);
        issue(enc_i(12'h7FF, 5'd11, 3'd4, 5'd12), 0);
        drain();
        chk("illegal gap", 32'(acc_t[acc_t.size()-4] - acc_t[acc_t.size()-5]), 32'd20);
        chk("illegal gap 2", 32'(acc_t[acc_t.size()-3] - acc_t[acc_t.size()-4]), 32'd20);
        chk("hold gap", 32'(acc_t[acc_t.size()-2] - acc_t[acc_t.size()-3]), 32'd40);
        chk("hold gap 2", 32'(acc_t[acc_t.size()-1] - acc_t[acc_t.size()-2]), 32'd40);
        scan_regs();
        for (int i = 0; i < 80; i++) issue(rand_instr(), $urandom_range(0, 1) == 1);
        instr_valid = 0;
        drain();
        scan_regs();
        issue(enc_i(12'd9, 5'd0, 3'd0, 5'd7), 0);
        @(negedge clk);
        @(negedge clk);
        chk("exec before reset", 32'(alu_en), 32'h1);
        #2;
        rst_n = 0;
        exp_q.delete();
        foreach (regs[i]) regs[i] = 0;
        @(negedge clk);
        #1;
        check_quiet(1'b0);
        rst_n = 1;
        @(negedge clk);
        chk("ready after mid reset", 32'(instr_ready), 32'd1);
        scan_regs();
        issue(enc_i(12'hFFF, 5'd0, 3'd0, 5'd7), 0);
        drain();
        scan_regs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rv32_alu_sequencer.md
Name: rv32_alu_sequencer

Overview:
Issue/writeback controller that drives the per-operation ALU units (add, sub, xor, or, and, sll, srl, sra, slt, sltu) from the control side. It accepts one RV32I OP or OP-IMM instruction per handshake and reads operands from an internal 32x32 register file. It asserts exactly one ALU enable, captures the ALU result and writes it back to rd. It is the instruction-level driver for the enable-gated ALU datapath.

Parameters:
XLEN, 32, datapath width
NREGS, 32, register count (x0 hardwired to zero)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
instr_valid  input  1  instruction offered
instr  input  32  RV32I instruction word
instr_ready  output  1  sequencer can accept (IDLE only)
alu_en  output  10  one-hot ALU enable: [0]add [1]sub [2]xor [3]or [4]and [5]sll [6]srl [7]sra [8]slt [9]sltu
alu_rs1  output  32  operand A to ALU
alu_rs2  output  32  operand B to ALU
alu_result  input  32  selected ALU unit's rd_data
done  output  1  one-cycle pulse: instruction retired
illegal  output  1  one-cycle pulse: instruction rejected, no writeback
wb_en  output  1  one-cycle pulse: register write occurring
wb_addr  output  5  destination of current write
wb_data  output  32  value written
dbg_addr  input  5  debug read address
dbg_data  output  32  combinational read of regfile[dbg_addr], 0 for x0

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n=0 at posedge): state=IDLE; all registers x1..x31 = 0; every output = 0, including instr_ready, alu_en, alu_rs1, alu_rs2, done, illegal, wb_*.
- instr_ready=1 in IDLE when rst_n=1; 0 in all other states.
- FSM: IDLE -> DECODE -> EXEC -> WB -> IDLE. Fixed 4 cycles from accept to done. Max throughput is 1 instruction per 4 cycles.
- IDLE: on instr_valid && instr_ready, latch instr and go to DECODE. Otherwise hold.
- DECODE:
  - Read rs1 and rs2 from the regfile; x0 reads as 0.
  - Register alu_rs1, alu_rs2 and a one-hot alu_en.
  - If the encoding is illegal: alu_en=0, pulse illegal in this cycle, return to IDLE (2-cycle reject).
- EXEC: hold alu_en, alu_rs1 and alu_rs2 stable. Capture alu_result at the end of the cycle.
- WB:
  - alu_en=0.
  - If rd!=0: wb_en=1, write regfile[rd]=captured result.
  - rd==0: no write, wb_en=0.
  - done=1. Next state IDLE.
- Decode, opcode 0110011 (OP), keyed on funct7/funct3:
  - 0000000/000 add; 0100000/000 sub
  - 0000000/001 sll; 0000000/010 slt; 0000000/011 sltu; 0000000/100 xor
  - 0000000/101 srl; 0100000/101 sra
  - 0000000/110 or; 0000000/111 and
  - Any other funct7 is illegal.
- Decode, opcode 0010011 (OP-IMM):
  - alu_rs2 = sign-extended instr[31:20].
  - funct3: 000 add, 010 slt, 011 sltu, 100 xor, 110 or, 111 and.
  - Shifts: 001 requires funct7=0000000 (sll); 101 with funct7=0000000 is srl, with 0100000 is sra. Other funct7 values are illegal.
- Any other opcode is illegal.
- Shifts (both opcodes): alu_rs2 = {27'b0, shamt[4:0]}, so the ALU never sees a shift count >31.
- alu_en is never multi-hot. It is all-zero outside EXEC, except for the cycle it is registered at DECODE→EXEC. The ALU units hold their output while disabled, so alu_result is sampled only at the end of EXEC.
- Hazards: a regfile write in WB completes before the next DECODE read, so no forwarding is needed. Back-to-back dependent instructions see the updated value.
- Reset mid-instruction: abort immediately, no writeback, no done.
- instr_valid while busy is ignored. The instruction is not consumed and must be held by the source.
- dbg_data reflects a write in the cycle after wb_en.

Decomposition:
- Package rv32_alu_pkg holds:
  - opcode constants OPC_OP=7'b0110011 and OPC_OPIMM=7'b0010011
  - funct3/funct7 constants
  - alu_en bit indices EN_ADD..EN_SLTU and the width ALU_EN_W=10
  - FSM state enum {IDLE, DECODE, EXEC, WB}
- One sub-module, rv32_regfile: 31x32 storage with synchronous reset, one write port, three combinational read ports (rs1, rs2, dbg), and x0 forced to 0.

Test Plan:
- Reset then addi x1,x0,5 (0x00500093) → alu_en=0x001, alu_rs2=5 in EXEC; done at cycle 4; wb_addr=1, wb_data=5; dbg_data(x1)=5.
- x1=5, then sub x2,x0,x1 → alu_en=0x002; x2=0xFFFFFFFB. Next slt x3,x2,x1 gives x3=1, and sltu x4,x2,x1 gives x4=0.
- sll x5,x1,x6 with x6=0x00000021 → alu_rs2=1 (masked); x5=0x0000000A. srai with shamt=4 on 0x80000000 → alu_en=0x080, alu_rs2=4.
- Illegal funct7 (add with funct7=0000001), then opcode 0000011 → illegal pulses in DECODE; no wb_en; instr_ready returns at cycle 2; regfile unchanged.
- addi x0,x0,7 → done=1, wb_en=0, dbg_data(x0)=0. Hold instr_valid high across 3 instructions → exactly one accept per 4 cycles, and alu_en is never multi-hot.
- rst_n=0 during EXEC of addi x7,x0,9 → no done, x7=0, all outputs 0 next cycle; instr_ready=1 one cycle after rst_n rises.
